march_element_sequencer: RTL

Control stage directly upstream of the BIST address counter. It runs one march element per start request: it loads the counter with the first or last address, holds each address while a programmable number of memory operations execute, then steps to the next address until the element's address space is exhausted. It drives the counter's `s_in`, `r_in`, `hold_in`, `updwn_in` and `admd_in` inputs, and it tells the downstream data/compare logic when an address and operation index are valid.

---
 rtl/march_element_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/march_element_sequencer.sv
// Sequences one march element: loads the BIST address counter, holds each address
// for nops+1 operation cycles, then steps it until the element's address space is covered.
module march_element_sequencer #(
    parameter int                tasw      = 8,
    parameter int                admw      = 2,
    parameter logic [admw-1:0]   admd_prud = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic            abort_in,
    input  logic            updwn_in,
    input  logic [admw-1:0] admd_in,
    input  logic [2:0]      nops_in,
    output logic            s_out,
    output logic            r_out,
    output logic            hold_out,
    output logic            updwn_out,
    output logic [admw-1:0] admd_out,
    output logic            op_valid_out,
    output logic [2:0]      op_idx_out,
    output logic            busy_out,
    output logic            done_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OPS,
        STEP,
        DONE
    } state_t;

    state_t        state;
    logic [2:0]    nops_q;
    logic [tasw:0] visit_cnt;
    logic [tasw:0] last_visit;

    // The LFSR never visits zero, so a pseudo-random element is one address shorter.
    localparam logic [tasw:0] FULL_LAST = {1'b0, {tasw{1'b1}}};
    localparam logic [tasw:0] PRUD_LAST = FULL_LAST - 1'b1;

    assign last_visit = (admd_out == admd_prud) ? PRUD_LAST : FULL_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            nops_q       <= 3'd0;
            visit_cnt    <= '0;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            hold_out     <= 1'b1;
            updwn_out    <= 1'b0;
            admd_out     <= '0;
            op_valid_out <= 1'b0;
            op_idx_out   <= 3'd0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else if (abort_in) begin
            // Latched mode and direction stay visible until the next accepted start.
            state        <= IDLE;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            hold_out     <= 1'b1;
            op_valid_out <= 1'b0;
            op_idx_out   <= 3'd0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state     <= LOAD;
                        updwn_out <= updwn_in;
                        admd_out  <= admd_in;
                        nops_q    <= nops_in;
                        visit_cnt <= '0;
                        busy_out  <= 1'b1;
                        hold_out  <= 1'b0;
                        s_out     <= ~updwn_in;
                        r_out     <= updwn_in;
                    end
                end
                LOAD: begin
                    state        <= OPS;
                    s_out        <= 1'b0;
                    r_out        <= 1'b0;
                    hold_out     <= 1'b1;
                    op_valid_out <= 1'b1;
                    op_idx_out   <= 3'd0;
                end
                OPS: begin
                    if (op_idx_out == nops_q) begin
                        op_idx_out   <= 3'd0;
                        op_valid_out <= 1'b0;
                        if (visit_cnt == last_visit) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state    <= STEP;
                            hold_out <= 1'b0;
                        end
                    end else begin
                        op_idx_out <= op_idx_out + 3'd1;
                    end
                end
                STEP: begin
                    state        <= OPS;
                    visit_cnt    <= visit_cnt + 1'b1;
                    hold_out     <= 1'b1;
                    op_valid_out <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    s_out        <= 1'b0;
                    r_out        <= 1'b0;
                    hold_out     <= 1'b1;
                    op_valid_out <= 1'b0;
                    op_idx_out   <= 3'd0;
                    busy_out     <= 1'b0;
                    done_out     <= 1'b0;
                end
            endcase
        end
    end

endmodule
